junction_phase_scheduler: RTL and testbench

//  Actuated phase scheduler for a 4-approach junction. Grants green to one approach at a time from

---
 rtl/junction_phase_scheduler_pkg.sv | 27 ++
 rtl/junction_phase_scheduler_if.sv | 42 ++++
 rtl/junction_phase_scheduler_rr_arbiter.sv | 40 ++++
 rtl/junction_phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_junction_phase_scheduler.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/junction_phase_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// jps_pkg
// Shared definitions for the junction phase scheduler: state encodings,
// lamp codes and register widths.
// ----------------------------------------------------------------------------
package jps_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 4;

    typedef logic [STATE_W-1:0] state_t;

    // Encodings are exposed on the ps output, so they are fixed values.
    // 5..7 are unused and fall back to IDLE.
    localparam state_t IDLE   = 3'd0;
    localparam state_t GREEN  = 3'd1;
    localparam state_t YELLOW = 3'd2;
    localparam state_t ALLRED = 3'd3;
    localparam state_t EMG    = 3'd4;

    typedef logic [2:0] lamp_t;

    localparam lamp_t RED = 3'b100;
    localparam lamp_t YEL = 3'b010;
    localparam lamp_t GRN = 3'b001;

endpackage

// File: rtl/junction_phase_scheduler_if.sv
// ----------------------------------------------------------------------------
// junction_phase_scheduler_if
// Sensor/lamp bundle between the junction controller and the scheduler.
//   master : drives req, emg_req, emg_dir; observes the lamp/status outputs
//   slave  : the scheduler itself
// Signals:
//   req      per-approach vehicle present (level)
//   emg_req  emergency preemption request (level)
//   emg_dir  approach to preempt for
//   light    3-bit lamp per approach, light[3i+2:3i]
//   grant    approach owning the phase
//   emg_ack  high while preempted
//   count    cycles spent in the present state
//   ps       present state
// ----------------------------------------------------------------------------
interface junction_phase_scheduler_if #(
    parameter int N_APPR = 4
);
    import jps_pkg::*;

    localparam int GW = $clog2(N_APPR);

    logic [N_APPR-1:0]   req;
    logic                emg_req;
    logic [GW-1:0]       emg_dir;
    logic [3*N_APPR-1:0] light;
    logic [GW-1:0]       grant;
    logic                emg_ack;
    logic [CNT_W-1:0]    count;
    state_t              ps;

    modport master (
        output req, emg_req, emg_dir,
        input  light, grant, emg_ack, count, ps
    );

    modport slave (
        input  req, emg_req, emg_dir,
        output light, grant, emg_ack, count, ps
    );

endinterface

// File: rtl/junction_phase_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Search starts at ptr+1 and wraps, so the
// approach at ptr itself has the lowest priority (and still wins if alone).
// Ports:
//   req      request vector
//   ptr      last granted approach
//   winner   index of the selected approach (0 when nothing requests)
//   any_req  OR of all requests
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);

    logic         found;
    logic [W-1:0] idx;

    // NOTE: every variable written in a combinational block gets a default
    // at the top; a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        idx     = '0;
        any_req = |req;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// ----------------------------------------------------------------------------
// junction_phase_scheduler
// Actuated phase scheduler for an N_APPR-approach junction: one approach is
// green at a time, chosen round-robin from vehicle requests, with min/max
// green, yellow and all-red clearance, and emergency preemption.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active high
//   bus   junction_phase_scheduler_if.slave (requests in, lamps/status out)
// All outputs are decoded from registers only (Moore).
// ----------------------------------------------------------------------------
module junction_phase_scheduler
    import jps_pkg::*;
#(
    parameter int N_APPR    = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input logic                        clk,
    input logic                        rst,
    junction_phase_scheduler_if.slave  bus
);

    localparam int GW = $clog2(N_APPR);

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);

    state_t           ps_q, ps_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [GW-1:0]     rr_winner;
    logic              rr_any;
    logic [N_APPR-1:0] grant_oh;
    logic              own_req;
    logic              others;
    logic              min_done;
    logic              at_max;

    rr_arbiter #(.N(N_APPR), .W(GW)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .winner  (rr_winner),
        .any_req (rr_any)
    );

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q    <= IDLE;
            grant_q <= '0;
            ptr_q   <= GW'(N_APPR - 1);
            count_q <= '0;
        end else begin
            ps_q    <= ps_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        ps_d    = ps_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;

        for (int a = 0; a < N_APPR; a++)
            grant_oh[a] = (GW'(a) == grant_q);

        own_req  = |(bus.req & grant_oh);
        others   = |(bus.req & ~grant_oh);
        min_done = (count_q >= GMIN_M1);
        at_max   = (count_q == GMAX_M1);

        case (ps_q)
            IDLE, ALLRED: begin
                // ALLRED only decides once its clearance time has elapsed;
                // IDLE decides every cycle. Emergency outranks requests.
                if (ps_q == IDLE || count_q == AR_M1) begin
                    if (bus.emg_req) begin
                        ps_d    = EMG;
                        grant_d = bus.emg_dir;
                        ptr_d   = bus.emg_dir;
                    end else if (rr_any) begin
                        ps_d    = GREEN;
                        grant_d = rr_winner;
                        ptr_d   = rr_winner;
                    end else begin
                        ps_d    = IDLE;
                    end
                end
            end

            GREEN: begin
                if (bus.emg_req) begin
                    // Preemption for the approach already green keeps the
                    // lamp green; any other direction clears immediately.
                    if (bus.emg_dir == grant_q) begin
                        ps_d  = EMG;
                        ptr_d = grant_q;
                    end else begin
                        ps_d  = YELLOW;
                    end
                end else if (min_done && others && (!own_req || at_max)) begin
                    ps_d = YELLOW;
                end
            end

            YELLOW: begin
                if (count_q == YEL_M1)
                    ps_d = ALLRED;
            end

            EMG: begin
                if (!bus.emg_req)
                    ps_d = YELLOW;
            end

            default: ps_d = IDLE;
        endcase

        // count restarts on any state change; GREEN holds at GREEN_MAX-1 so
        // the max-green test stays true while resting, elsewhere it holds
        // at all-ones rather than wrapping.
        if (ps_d != ps_q)
            count_d = '0;
        else if (ps_q == GREEN)
            count_d = at_max ? count_q : count_q + 1'b1;
        else
            count_d = (&count_q) ? count_q : count_q + 1'b1;
    end

    // ---------------- output decode ----------------
    always_comb begin
        bus.light = {N_APPR{RED}};
        for (int a = 0; a < N_APPR; a++) begin
            if (GW'(a) == grant_q) begin
                if (ps_q == GREEN || ps_q == EMG)
                    bus.light[3*a +: 3] = GRN;
                else if (ps_q == YELLOW)
                    bus.light[3*a +: 3] = YEL;
            end
        end
        bus.grant   = grant_q;
        bus.emg_ack = (ps_q == EMG);
        bus.count   = count_q;
        bus.ps      = ps_q;
    end

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// ----------------------------------------------------------------------------
// tb_junction_phase_scheduler
// Directed checks of the junction phase scheduler: reset state, resting
// green, round-robin alternation with max green, early end after own request
// drops, emergency preemption from IDLE/GREEN/ALLRED, and pointer wrap.
// ----------------------------------------------------------------------------
module tb_junction_phase_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    junction_phase_scheduler_if #(.N_APPR(4)) bus ();

    junction_phase_scheduler #(
        .N_APPR    (4),
        .GREEN_MIN (4),
        .GREEN_MAX (10),
        .YELLOW_T  (2),
        .ALLRED_T  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       emg_req;
        logic [1:0] emg_dir;
        logic [2:0] ps;
        logic [1:0] grant;
        logic [3:0] count;
        logic       ack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] r, input logic e, input logic [1:0] d,
                                input logic [2:0] p, input logic [1:0] g,
                                input logic [3:0] c, input logic k);
        vec_t v;
        v.req = r; v.emg_req = e; v.emg_dir = d;
        v.ps = p; v.grant = g; v.count = c; v.ack = k;
        return v;
    endfunction

    // Expected lamps from expected state/grant.
    function automatic logic [11:0] exp_light(input logic [2:0] p, input logic [1:0] g);
        logic [11:0] l;
        l = 12'h924;
        if (p == 3'd1 || p == 3'd4) l[3*g +: 3] = 3'b001;
        else if (p == 3'd2)         l[3*g +: 3] = 3'b010;
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input vec_t v);
        int nonred;
        check({tag, " ps"},    32'(bus.ps),      32'(v.ps));
        check({tag, " grant"}, 32'(bus.grant),   32'(v.grant));
        check({tag, " count"}, 32'(bus.count),   32'(v.count));
        check({tag, " ack"},   32'(bus.emg_ack), 32'(v.ack));
        check({tag, " light"}, 32'(bus.light),   32'(exp_light(v.ps, v.grant)));
        nonred = 0;
        for (int a = 0; a < 4; a++)
            if (bus.light[3*a +: 3] != 3'b100) nonred++;
        check({tag, " one_lamp"}, 32'(nonred <= 1), 32'd1);
        check({tag, " ps_valid"}, 32'(bus.ps <= 3'd4), 32'd1);
    endtask

    // Apply inputs, advance one clock, sample 1 unit after the edge.
    task automatic step(input string tag, input vec_t v);
        bus.req     = v.req;
        bus.emg_req = v.emg_req;
        bus.emg_dir = v.emg_dir;
        @(posedge clk);
        #1;
        check_state(tag, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Directed table: starts in ALLRED, grant 0, after the alternation run.
        tbl.push_back(mk(4'b0001, 0, 0, 3'd1, 0, 0, 0)); // lone request re-wins
        tbl.push_back(mk(4'b0011, 0, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 3'd1, 0, 2, 0)); // own request dropped
        tbl.push_back(mk(4'b0010, 0, 0, 3'd1, 0, 3, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 3'd2, 0, 0, 0)); // min green reached
        tbl.push_back(mk(4'b0010, 0, 0, 3'd2, 0, 1, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 3'd3, 0, 0, 0));
        tbl.push_back(mk(4'b0010, 0, 0, 3'd1, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 0, 3'd1, 1, 1, 0));
        tbl.push_back(mk(4'b0001, 1, 3, 3'd2, 1, 0, 0)); // preempt other dir, min waived
        tbl.push_back(mk(4'b0001, 1, 3, 3'd2, 1, 1, 0)); // yellow not shortened
        tbl.push_back(mk(4'b0001, 1, 3, 3'd3, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 1, 3, 3'd4, 3, 0, 1)); // emergency beats request
        tbl.push_back(mk(4'b0001, 1, 0, 3'd4, 3, 1, 1)); // emg_dir change ignored
        tbl.push_back(mk(4'b0001, 0, 0, 3'd2, 3, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 0, 3'd2, 3, 1, 0));
        tbl.push_back(mk(4'b0001, 0, 0, 3'd3, 3, 0, 0));
        tbl.push_back(mk(4'b1001, 0, 0, 3'd1, 0, 0, 0)); // wrap 3 -> 0
        tbl.push_back(mk(4'b1000, 0, 0, 3'd1, 0, 1, 0));
        tbl.push_back(mk(4'b1000, 0, 0, 3'd1, 0, 2, 0));
        tbl.push_back(mk(4'b1000, 0, 0, 3'd1, 0, 3, 0));
        tbl.push_back(mk(4'b1000, 0, 0, 3'd2, 0, 0, 0));
        tbl.push_back(mk(4'b1001, 0, 0, 3'd2, 0, 1, 0)); // req change in yellow unused
        tbl.push_back(mk(4'b0000, 0, 0, 3'd3, 0, 0, 0));
        tbl.push_back(mk(4'b1001, 0, 0, 3'd1, 3, 0, 0)); // search from 1 -> 3
        tbl.push_back(mk(4'b1001, 1, 3, 3'd4, 3, 0, 1)); // preempt own dir, stays green
        tbl.push_back(mk(4'b1001, 1, 3, 3'd4, 3, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd2, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd2, 3, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd3, 3, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd0, 3, 0, 0)); // nothing pending -> IDLE
        tbl.push_back(mk(4'b0000, 0, 0, 3'd0, 3, 1, 0));
        tbl.push_back(mk(4'b0000, 1, 2, 3'd4, 2, 0, 1)); // IDLE -> EMG
        tbl.push_back(mk(4'b0100, 0, 0, 3'd2, 2, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 0, 3'd2, 2, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd3, 2, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd0, 2, 0, 0));
        tbl.push_back(mk(4'b0100, 1, 1, 3'd4, 1, 0, 1)); // IDLE: emergency beats request
        tbl.push_back(mk(4'b0000, 0, 0, 3'd2, 1, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd2, 1, 1, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 3'd3, 1, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 0, 3'd1, 2, 0, 0));
        tbl.push_back(mk(4'b0100, 0, 0, 3'd1, 2, 1, 0));

        // Reset state while rst is held.
        bus.req = '0; bus.emg_req = 1'b0; bus.emg_dir = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", mk(4'b0000, 0, 0, 3'd0, 0, 0, 0));
        rst = 1'b0;

        // Lone request rests on green; count holds at GREEN_MAX-1.
        for (int k = 1; k <= 36; k++)
            step($sformatf("rest[%0d]", k),
                 mk(4'b0001, 0, 0, 3'd1, 0, (k - 1 > 9) ? 4'd9 : 4'(k - 1), 0));

        // Asynchronous reset mid-GREEN, between clock edges.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst ps",    32'(bus.ps),      32'd0);
        check("async_rst light", 32'(bus.light),   32'h924);
        check("async_rst count", 32'(bus.count),   32'd0);
        check("async_rst ack",   32'(bus.emg_ack), 32'd0);
        check("async_rst grant", 32'(bus.grant),   32'd0);
        #1;
        rst = 1'b0;

        // Two competing approaches: max green, yellow, all-red, alternate 0,2,0.
        for (int ph = 0; ph < 3; ph++) begin
            logic [1:0] g;
            g = (ph == 1) ? 2'd2 : 2'd0;
            for (int c = 0; c < 10; c++)
                step($sformatf("alt%0d g[%0d]", ph, c), mk(4'b0101, 0, 0, 3'd1, g, 4'(c), 0));
            step($sformatf("alt%0d y0", ph), mk(4'b0101, 0, 0, 3'd2, g, 0, 0));
            step($sformatf("alt%0d y1", ph), mk(4'b0101, 0, 0, 3'd2, g, 1, 0));
            step($sformatf("alt%0d ar", ph), mk(4'b0101, 0, 0, 3'd3, g, 0, 0));
        end

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl[%0d]", i), tbl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
